instr_issue_queue: RTL and testbench

Upstream feeder for the CPU `top`. It buffers 16-bit instruction words written by a host or loader into a small FIFO and issues them to the CPU's `instruction_in`/`instruction_valid` pins as single-cycle strobes. Issues are spaced at least `GAP` cycles apart and can be paused with `hold`. The CPU has no ready/backpressure, so this block alone owns issue pacing.

---
 rtl/instr_issue_queue.sv | 189 ++++++++++++++++++
 tb/tb_instr_issue_queue.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// -----------------------------------------------------------------------------
// instr_issue_queue
//
// Buffers 16-bit instruction words from a host/loader in a small FIFO and
// issues them to the CPU as registered single-cycle strobes. Consecutive
// strobes are spaced at least GAP cycles apart, and issue can be paused with
// `hold`. The CPU has no backpressure, so all pacing is decided here.
//
// Optional feature macro: INSTR_DROP_NOP_EN
//   defined   -> a head word of 16'h0000 is popped silently. It takes one
//                cycle, does not start a gap countdown, and leaves
//                instruction_out unchanged.
//   undefined -> NOP words are issued like any other word.
//
// Reset `rst` is asynchronous and active-low.
// -----------------------------------------------------------------------------
module instr_issue_queue #(
    parameter int DEPTH = 8,  // FIFO entries, power of two, >= 2
    parameter int GAP   = 1   // minimum cycles between strobes, >= 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             wr_instr,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic                    hold,
    output logic [15:0]             instruction_out,
    output logic                    instruction_valid,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    empty,
    output logic                    overflow,
    input  logic                    ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    // Wide enough to hold GAP-1; a single bit when GAP==1 (counter unused).
    localparam int CNT_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,   // free to pop whenever the queue has a word and hold is low
        S_ISSUE,  // strobe is on the output this cycle
        S_WAIT    // counting down the remainder of the issue gap
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [15:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [15:0]        head;
    logic               full;
    logic               push;
    logic               pop;
    logic               strobe;
    logic               gap_open;
    logic               head_is_nop;

    // Status flags come from registered occupancy only, so a pop can never
    // reopen wr_ready within the same cycle.
    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign wr_ready = !full;
    assign push     = wr_valid && wr_ready;
    assign head     = mem[rd_ptr];

`ifdef INSTR_DROP_NOP_EN
    assign head_is_nop = (head == 16'h0000);
`else
    assign head_is_nop = 1'b0;
`endif

    // Issue FSM state and gap counter registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: decide whether the gap is open and whether to pop.
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        strobe   = 1'b0;
        gap_open = 1'b0;

        case (state_q)
            S_IDLE: begin
                gap_open = 1'b1;
            end
            S_ISSUE: begin
                if (GAP == 1) begin
                    // Back-to-back: the issue cycle doubles as an idle cycle.
                    gap_open = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(GAP - 1);
                end
            end
            S_WAIT: begin
                // The countdown runs regardless of hold; at 1 it expires and
                // this cycle behaves like IDLE.
                if (cnt_q == CNT_W'(1)) begin
                    gap_open = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (gap_open) begin
            state_d = S_IDLE;
            if (!empty && !hold) begin
                pop = 1'b1;
                if (!head_is_nop) begin
                    strobe  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
        end
    end

    // Instruction storage; written only on an accepted push.
    // NOTE: the storage array has no reset: occupancy and pointers define
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_instr;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves level alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Registered issue outputs; instruction_out keeps the last issued word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instruction_out   <= '0;
            instruction_valid <= 1'b0;
        end else begin
            instruction_valid <= strobe;
            if (strobe) begin
                instruction_out <= head;
            end
        end
    end

    // Sticky overflow: a write while full sets it, and set beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (wr_valid && !wr_ready) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_issue_queue
//
// Two instances share a clock, reset, hold and ovf_clr: u_g1 (GAP=1) and
// u_g3 (GAP=3). Only the instance selected by `sel` sees write requests, so
// the other stays empty and must never strobe. Expected strobes (word and
// the cycle they must appear in) are queued when stimulus is issued; a
// monitor per instance pops and compares on every strobe it sees.
// -----------------------------------------------------------------------------
module tb_instr_issue_queue;

    typedef struct {
        logic [15:0] word;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wr_instr;
    logic        wr_valid;
    logic        hold;
    logic        ovf_clr;
    int          sel;

    logic        wv1, wv3;
    logic        wr_ready1, wr_ready3;
    logic [15:0] out1, out3;
    logic        v1, v3;
    logic [3:0]  level1, level3;
    logic        empty1, empty3;
    logic        ovf1, ovf3;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    exp_t        q1[$];
    exp_t        q3[$];
    exp_t        e1, e3;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign wv1 = wr_valid && (sel == 1);
    assign wv3 = wr_valid && (sel == 3);

    instr_issue_queue #(.DEPTH(8), .GAP(1)) u_g1 (
        .clk(clk), .rst(rst), .wr_instr(wr_instr), .wr_valid(wv1),
        .wr_ready(wr_ready1), .hold(hold), .instruction_out(out1),
        .instruction_valid(v1), .level(level1), .empty(empty1),
        .overflow(ovf1), .ovf_clr(ovf_clr)
    );

    instr_issue_queue #(.DEPTH(8), .GAP(3)) u_g3 (
        .clk(clk), .rst(rst), .wr_instr(wr_instr), .wr_valid(wv3),
        .wr_ready(wr_ready3), .hold(hold), .instruction_out(out3),
        .instruction_valid(v3), .level(level3), .empty(empty3),
        .overflow(ovf3), .ovf_clr(ovf_clr)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wr(input logic [15:0] w);
        wr_instr = w;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic exp1(input logic [15:0] w, input int c);
        exp_t e;
        e.word = w;
        e.cyc  = c;
        q1.push_back(e);
    endtask

    task automatic exp3(input logic [15:0] w, input int c);
        exp_t e;
        e.word = w;
        e.cyc  = c;
        q3.push_back(e);
    endtask

    // Cycle counter always advances, so this wait is bounded.
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Strobe monitor for the GAP=1 instance.
    always @(negedge clk) begin
        if (rst === 1'b1 && v1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL g1_strobe unexpected word=%h cyc=%0d expected=none", out1, cyc);
            end else begin
                e1 = q1.pop_front();
                if (out1 !== e1.word || cyc != e1.cyc) begin
                    failures++;
                    $display("FAIL g1_strobe word=%h cyc=%0d expected word=%h cyc=%0d",
                             out1, cyc, e1.word, e1.cyc);
                end
            end
        end
    end

    // Strobe monitor for the GAP=3 instance.
    always @(negedge clk) begin
        if (rst === 1'b1 && v3 === 1'b1) begin
            checks++;
            if (q3.size() == 0) begin
                failures++;
                $display("FAIL g3_strobe unexpected word=%h cyc=%0d expected=none", out3, cyc);
            end else begin
                e3 = q3.pop_front();
                if (out3 !== e3.word || cyc != e3.cyc) begin
                    failures++;
                    $display("FAIL g3_strobe word=%h cyc=%0d expected word=%h cyc=%0d",
                             out3, cyc, e3.word, e3.cyc);
                end
            end
        end
    end

    initial begin
        int c;
        int d;

        rst      = 1'b0;
        wr_instr = '0;
        wr_valid = 1'b0;
        hold     = 1'b0;
        ovf_clr  = 1'b0;
        sel      = 1;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out1",   out1,      16'h0000);
        check("rst_v1",     v1,        1'b0);
        check("rst_level1", level1,    0);
        check("rst_empty1", empty1,    1'b1);
        check("rst_ready1", wr_ready1, 1'b1);
        check("rst_ovf1",   ovf1,      1'b0);
        check("rst_v3",     v3,        1'b0);
        check("rst_level3", level3,    0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back program, GAP=1: strobe one cycle after each write.
        sel = 1;
        c = cyc;
        exp1(16'h012D, c + 2);
        exp1(16'h0236, c + 3);
        exp1(16'h0300, c + 4);
        wr(16'h012D);
        wr(16'h0236);
        wr(16'h0300);
        wait_until(c + 6);
        check("b2b_level1", level1, 0);
        check("b2b_empty1", empty1, 1'b1);

        // Spacing, GAP=3: queue under hold, release, strobes 3 cycles apart.
        sel  = 3;
        hold = 1'b1;
        wr(16'h012D);
        wr(16'h0236);
        wr(16'h0300);
        check("gap_level3_queued", level3, 3);
        d = cyc;
        exp3(16'h012D, d + 1);
        exp3(16'h0236, d + 4);
        exp3(16'h0300, d + 7);
        hold = 1'b0;
        wait_until(d + 1);
        check("gap_level3_a", level3, 2);
        wait_until(d + 4);
        check("gap_level3_b", level3, 1);
        wait_until(d + 7);
        check("gap_level3_c", level3, 0);
        check("gap_empty3",   empty3, 1'b1);
        repeat (4) @(negedge clk);

        // Full / overflow, DEPTH=8, GAP=1.
        sel  = 1;
        hold = 1'b1;
        for (int i = 0; i < 8; i++) wr(16'h1000 + 16'(i));
        check("full_level1",   level1,    8);
        check("full_ready1",   wr_ready1, 1'b0);
        check("full_ovf_pre",  ovf1,      1'b0);
        wr(16'h10FF);
        check("ovf_set",       ovf1,      1'b1);
        check("ovf_level1",    level1,    8);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr",       ovf1,      1'b0);
        d = cyc;
        for (int i = 0; i < 8; i++) exp1(16'h1000 + 16'(i), d + 1 + i);
        hold = 1'b0;
        wait_until(d + 1);
        check("drain_ready1",  wr_ready1, 1'b1);
        check("drain_level1",  level1,    7);
        wait_until(d + 8);
        check("drain_done1",   level1,    0);
        repeat (3) @(negedge clk);

        // Hold mid-stream, GAP=1: hold high for 5 cycles after 2nd strobe.
        hold = 1'b1;
        wr(16'h2001);
        wr(16'h2002);
        wr(16'h2003);
        wr(16'h2004);
        d = cyc;
        exp1(16'h2001, d + 1);
        exp1(16'h2002, d + 2);
        exp1(16'h2003, d + 8);
        exp1(16'h2004, d + 9);
        hold = 1'b0;
        wait_until(d + 2);
        hold = 1'b1;
        check("hold_level1_a", level1, 2);
        wait_until(d + 7);
        check("hold_level1_b", level1, 2);
        check("hold_out1",     out1,   16'h2002);
        hold = 1'b0;
        wait_until(d + 10);
        check("hold_level1_c", level1, 0);
        repeat (2) @(negedge clk);

        // NOP handling, GAP=1.
        c = cyc;
        exp1(16'h012D, c + 2);
`ifdef INSTR_DROP_NOP_EN
        exp1(16'h0300, c + 4);
`else
        exp1(16'h0000, c + 3);
        exp1(16'h0300, c + 4);
`endif
        wr(16'h012D);
        wr(16'h0000);
        wr(16'h0300);
`ifdef INSTR_DROP_NOP_EN
        wait_until(c + 3);
        check("nop_out_kept", out1, 16'h012D);
        check("nop_no_strobe", v1, 1'b0);
`endif
        wait_until(c + 6);
        check("nop_level1", level1, 0);

        // Reset mid-stream during WAIT with 3 words queued, GAP=3.
        sel  = 3;
        hold = 1'b1;
        wr(16'h3001);
        wr(16'h3002);
        wr(16'h3003);
        wr(16'h3004);
        d = cyc;
        exp3(16'h3001, d + 1);
        hold = 1'b0;
        wait_until(d + 2);
        check("mid_level3_pre", level3, 3);
        check("mid_out3_pre",   out3,   16'h3001);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_v3",     v3,        1'b0);
        check("mid_rst_out3",   out3,      16'h0000);
        check("mid_rst_level3", level3,    0);
        check("mid_rst_empty3", empty3,    1'b1);
        check("mid_rst_ready3", wr_ready3, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_level3", level3, 0);
        check("post_rst_ready3", wr_ready3, 1'b1);

        // Every expected strobe must have been consumed by its monitor.
        check("q1_drained", q1.size(), 0);
        check("q3_drained", q3.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
